// File: rtl/lcrc_checker.sv
// Link-layer LCRC checker: accumulates a CRC-32 over each frame and reports ok/crc/length status.
// Define LCRC_ERR_CNT_EN to add the saturating err_count_o output and its counter.
module lcrc_checker #(
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [31:0]                          in_data_i,
  input  logic                                 in_valid_i,
  input  logic                                 in_sop_i,
  input  logic                                 in_eop_i,
  output logic                                 in_ready_o,
  output logic                                 chk_done_o,
  output logic                                 chk_ok_o,
  output logic                                 chk_crc_err_o,
  output logic                                 chk_len_err_o,
  output logic [$clog2(MAX_WORDS+1)-1:0]       frame_words_o
`ifdef LCRC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]                     err_count_o
`endif
);

  localparam int unsigned CntW   = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] Poly   = 32'h04C1_1DB7;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WORDS);

  typedef enum logic [1:0] {StIdle, StAccum, StDrop, StReport} state_e;

  function automatic logic [31:0] brev_bytes(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = w[8*b+7-i];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] crc_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    logic [31:0] d;
    c = crc;
    d = brev_bytes(data);
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ Poly;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  state_e          state_q, state_d;
  logic [31:0]     crc_q, crc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            held_q, held_d;
  logic [31:0]     held_data_q, held_data_d;
  logic            held_eop_q, held_eop_d;
  logic            crc_err_q, crc_err_d;
  logic            len_err_q, len_err_d;

  logic        accept;
  logic        start_vld;
  logic [31:0] start_data;
  logic        start_eop;

  assign accept = in_valid_i && (state_q != StReport);

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    held_d      = held_q;
    held_data_d = held_data_q;
    held_eop_d  = held_eop_q;
    crc_err_d   = crc_err_q;
    len_err_d   = len_err_q;
    start_vld   = 1'b0;
    start_data  = in_data_i;
    start_eop   = in_eop_i;

    unique case (state_q)
      StIdle: begin
        if (accept && in_sop_i) start_vld = 1'b1;
      end
      StAccum: begin
        if (accept) begin
          if (in_sop_i) begin
            // Abort: report the open frame now, replay this sop after REPORT.
            held_d      = 1'b1;
            held_data_d = in_data_i;
            held_eop_d  = in_eop_i;
            crc_err_d   = 1'b0;
            len_err_d   = 1'b1;
            state_d     = StReport;
          end else if (in_eop_i) begin
            crc_err_d = (in_data_i != brev_bytes(crc_q));
            len_err_d = 1'b0;
            state_d   = StReport;
          end else if (cnt_q == MaxCnt) begin
            state_d = StDrop;
          end else begin
            crc_d = crc_word(crc_q, in_data_i);
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDrop: begin
        if (accept && in_eop_i) begin
          crc_err_d = 1'b0;
          len_err_d = 1'b1;
          state_d   = StReport;
        end
      end
      StReport: begin
        held_d = 1'b0;
        if (held_q) begin
          start_vld  = 1'b1;
          start_data = held_data_q;
          start_eop  = held_eop_q;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame start, from a live sop in IDLE or a sop held across an abort report.
    if (start_vld) begin
      if (start_eop) begin
        state_d   = StReport;
        crc_d     = '0;
        cnt_d     = '0;
        crc_err_d = (start_data != 32'h0);
        len_err_d = 1'b0;
      end else begin
        state_d = StAccum;
        crc_d   = crc_word(32'h0, start_data);
        cnt_d   = CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      crc_q       <= '0;
      cnt_q       <= '0;
      held_q      <= 1'b0;
      held_data_q <= '0;
      held_eop_q  <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      held_data_q <= held_data_d;
      held_eop_q  <= held_eop_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
    end
  end

  assign in_ready_o    = (state_q != StReport);
  assign chk_done_o    = (state_q == StReport);
  assign chk_ok_o      = chk_done_o && !crc_err_q && !len_err_q;
  assign chk_crc_err_o = chk_done_o && crc_err_q;
  assign chk_len_err_o = chk_done_o && len_err_q;
  assign frame_words_o = chk_done_o ? cnt_q : '0;

`ifdef LCRC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_cnt_q <= '0;
    end else if (chk_done_o && (crc_err_q || len_err_q) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: doc/lcrc_checker.md
LCRC_CHECKER -- requirements
Module: lcrc_checker

Interface
REQ-001 Parameter MAX_WORDS, default 16, maximum data words per frame, excluding the LCRC word.
REQ-002 Parameter CNT_W, default 16, width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  32  frame word; the last word of each frame is the received LCRC.
REQ-006 in_valid  input  1  in_data qualifier; a word is accepted when in_valid && in_ready.
REQ-007 in_sop / in_eop  input  1 each  first-word / last-word markers; both may be set on one word.
REQ-008 in_ready  output  1  checker can accept a word.
REQ-009 chk_done  output  1  one-cycle pulse; result fields are valid in that cycle.
REQ-010 chk_ok  output  1  frame passed the LCRC check.
REQ-011 chk_crc_err  output  1  LCRC mismatch.
REQ-012 chk_len_err  output  1  length violation: overflow or aborted frame.
REQ-013 frame_words  output  $clog2(MAX_WORDS+1)  number of data words in the reported frame.
REQ-014 err_count  output  CNT_W  saturating error count; present only per REQ-035.

Function
REQ-015 The CRC polynomial SHALL be 0x04C11DB7, with a seed of 0x00000000 at each in_sop and no final complement.
REQ-016 Each data word SHALL be bit-reversed within each byte, then shifted into the CRC MSB-first (bit 31 down to 0), one full word per accepted cycle.
REQ-017 The expected LCRC SHALL be the final CRC, bit-reversed within each byte.
REQ-018 The expected LCRC SHALL be compared with the in_data of the in_eop word, which SHALL NOT enter the CRC.
REQ-019 States SHALL be IDLE, ACCUM, DROP and REPORT.
REQ-020 IDLE: an accepted in_sop without in_eop SHALL seed the CRC and go to ACCUM; an accepted in_sop with in_eop SHALL go to REPORT with zero data words.
REQ-021 IDLE: an accepted word without in_sop SHALL be discarded, with no report.
REQ-022 ACCUM: an accepted word without in_eop SHALL update the CRC and increment the word counter; an accepted in_eop word SHALL go to REPORT.
REQ-023 ACCUM: an accepted in_sop SHALL abort the current frame, which SHALL be reported in REPORT with chk_len_err=1 and chk_ok=0.
REQ-024 After an abort, the in_sop word SHALL be held and processed as a new frame start on leaving REPORT.
REQ-025 ACCUM: an accepted data word that would make the count MAX_WORDS+1 SHALL go to DROP; the word counter SHALL saturate at MAX_WORDS.
REQ-026 DROP: accepted words SHALL be discarded until in_eop, then the FSM SHALL go to REPORT with chk_len_err=1; a mismatch SHALL NOT also raise chk_crc_err.
REQ-027 REPORT SHALL last exactly one cycle with chk_done=1, then return to IDLE, or to ACCUM/REPORT for a held sop.
REQ-028 in_ready SHALL be 0 in REPORT and 1 in all other states.
REQ-029 Latency: chk_done SHALL assert in the cycle after the in_eop word (or aborting sop) is accepted.
REQ-030 Exactly one of chk_ok, chk_crc_err, chk_len_err SHALL be 1 while chk_done=1; all three SHALL be 0 otherwise.
REQ-031 in_valid=0 SHALL hold all state, the CRC and the counters unchanged.

Reset
REQ-032 Reset SHALL force state=IDLE, CRC=0, word counter=0, held-sop flag=0 and err_count=0.
REQ-033 Reset SHALL force chk_done=0, chk_ok=0, chk_crc_err=0, chk_len_err=0 and frame_words=0; in_ready SHALL be 1 while reset is asserted.
REQ-034 Reset asserted mid-frame SHALL discard the frame with no chk_done pulse.

Configuration
REQ-035 Macro LCRC_ERR_CNT_EN: when defined, err_count SHALL exist and increment, saturating at all-ones, on each chk_done with chk_crc_err or chk_len_err.
REQ-036 Without LCRC_ERR_CNT_EN, port err_count and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-037 Words {0x00000000 sop}, {0x00000000 eop} -> chk_done the next cycle, chk_ok=1, frame_words=1.
REQ-038 The same frame with LCRC 0x00000001 -> chk_crc_err=1; err_count 0->1 with LCRC_ERR_CNT_EN.
REQ-039 4 random data words plus the golden-model LCRC -> chk_ok=1, frame_words=4; flip in_data[0] of word 2 -> chk_crc_err=1.
REQ-040 MAX_WORDS=16, frame of 20 data words plus eop -> a single chk_done with chk_len_err=1 and frame_words=16.
REQ-041 sop, 2 data words, sop, eop with LCRC 0 -> chk_len_err report followed by a chk_ok report; in_ready=0 in each REPORT cycle.
REQ-042 reset pulse after 3 data words, then a valid 1-word frame -> no report for the aborted frame; the new frame gives chk_ok=1.
